regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Parameters
REQ-001 DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 ADDR_W, default 5, register address width; depth SHALL be 2**ADDR_W.
REQ-003 NRD, default 2, number of independent read ports, range 1..4.
REQ-004 ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-007 rd_addr  in  NRD*ADDR_W  read addresses, port i at slice i.
REQ-008 rd_data  out  NRD*DATA_W  read data, port i at slice i, combinational.
REQ-009 rd_pend  out  NRD  port i addresses a register with a pending write.
REQ-010 wr_en  in  1  write strobe.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 wr_be  in  DATA_W/8  byte enables; bit k covers wr_data[8k+7:8k].
REQ-014 sb_set  in  1  mark register sb_addr as pending (producer issued).
REQ-015 sb_addr  in  ADDR_W  scoreboard set address.
REQ-016 clr_req  in  1  start sequenced bulk clear; sampled in IDLE only.
REQ-017 clr_busy  out  1  high while clear FSM is in CLEAR.
REQ-018 clr_done  out  1  one-cycle pulse when clear completes.

Function
REQ-019 Write: on clk with wr_en=1 and FSM in IDLE, bytes of wr_addr with wr_be[k]=1 SHALL take wr_data; other bytes unchanged.
REQ-020 Write to register 0 with ZERO_REG=1 SHALL be discarded.
REQ-021 Read: rd_data[i] SHALL be stored value of rd_addr[i]; zero if ZERO_REG=1 and rd_addr[i]=0.
REQ-022 Bypass: if wr_en=1, IDLE, rd_addr[i]=wr_addr and the write is not discarded, enabled bytes of rd_data[i] SHALL come from wr_data in the same cycle; disabled bytes from storage.
REQ-023 Scoreboard: one pending bit per register; sb_set=1 SHALL set bit sb_addr next edge; an accepted write SHALL clear bit wr_addr next edge.
REQ-024 Simultaneous sb_set and accepted write to same address: pending bit SHALL end set (new producer wins).
REQ-025 Register 0 pending bit SHALL remain 0 when ZERO_REG=1.
REQ-026 rd_pend[i] SHALL equal pending bit of rd_addr[i]; no bypass on rd_pend.
REQ-027 FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clr_req=1; CLEAR->DONE after entry 2**ADDR_W-1 cleared; DONE->IDLE unconditionally.
REQ-028 CLEAR: an ADDR_W-bit index starting at 0 SHALL zero one register and its pending bit per cycle, incrementing; clear takes exactly 2**ADDR_W cycles.
REQ-029 In CLEAR and DONE, wr_en and sb_set SHALL be ignored (writes dropped, no bypass); reads return current storage.
REQ-030 clr_busy SHALL be 1 exactly in CLEAR; clr_done SHALL be 1 exactly in DONE.
REQ-031 clr_req in CLEAR or DONE SHALL be ignored; no queued restart.

Reset
REQ-032 rst_n=0 SHALL immediately force all registers to 0, all pending bits to 0, FSM to IDLE, clear index to 0, clr_busy=0, clr_done=0, including mid-clear.
REQ-033 rd_data SHALL read 0 and rd_pend 0 for every address while and after reset until written.

Verification
REQ-034 Write 0xDEADBEEF to r5 be=1111, next cycle read r5 on port 1 -> 0xDEADBEEF; same-cycle read during write -> 0xDEADBEEF via bypass.
REQ-035 r5=0xDEADBEEF, write 0x11223344 be=0101 -> rd_data=0xDE22BE44; write to r0 -> r0 reads 0.
REQ-036 sb_set r7, then write r7 -> rd_pend 1 one cycle after set, 0 after write; same-cycle set+write r7 -> rd_pend stays 1.
REQ-037 Fill all regs, pulse clr_req -> clr_busy high 32 cycles, clr_done pulses one cycle, all regs 0, writes issued during CLEAR lost.
REQ-038 Assert rst_n=0 at clear index 10 -> outputs zero asynchronously, FSM IDLE, clr_busy 0, no clr_done.
REQ-039 Parameter sweep DATA_W=64, ADDR_W=4, NRD=4, ZERO_REG=0 -> r0 writable, clear takes 16 cycles, byte enables 8 bits wide.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp : multi-read-port register file with byte-enable writes,      |
// |              write bypass, pending-write scoreboard and sequenced clear. |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  logic              is_idle;
  logic              wr_ok;
  logic              sb_ok;
  logic [DATA_W-1:0] wr_mask;

  // Writes and scoreboard sets only land in IDLE and never touch a hardwired r0.
  assign is_idle  = (state_q == S_IDLE);
  assign wr_ok    = wr_en  && is_idle && !((ZERO_REG != 0) && (wr_addr == '0));
  assign sb_ok    = sb_set && is_idle && !((ZERO_REG != 0) && (sb_addr == '0));
  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);

  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < NBYTE; k++) begin
      wr_mask[8*k +: 8] = {8{wr_be[k]}};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
    end
    case (state_q)
      S_IDLE: begin
        if (wr_ok) begin
          mem_d[wr_addr]  = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
          pend_d[wr_addr] = 1'b0;
        end
        // Applied after the write clear so a new producer wins the race.
        if (sb_ok) begin
          pend_d[sb_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        mem_d[idx_q]  = '0;
        pend_d[idx_q] = 1'b0;
        idx_d         = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      pend_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] stored;
      logic              hit;

      assign addr   = rd_addr[i*ADDR_W +: ADDR_W];
      assign stored = ((ZERO_REG != 0) && (addr == '0)) ? '0 : mem_q[addr];
      assign hit    = wr_ok && (wr_addr == addr);
      assign rd_data[i*DATA_W +: DATA_W] =
        hit ? ((stored & ~wr_mask) | (wr_data & wr_mask)) : stored;
      assign rd_pend[i] = pend_q[addr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_mp : self-checking bench for regfile_mp.                      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b1;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [3:0]       wr_be;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;

  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_pend;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [7:0]   b_wr_be;
  logic         b_sb_set;
  logic [3:0]   b_sb_addr;
  logic         b_clr_req;
  logic         b_clr_busy;
  logic         b_clr_done;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NRD(4), .ZERO_REG(0)) dut_wide (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_pend  (b_rd_pend),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .wr_be    (b_wr_be),
    .sb_set   (b_sb_set),
    .sb_addr  (b_sb_addr),
    .clr_req  (b_clr_req),
    .clr_busy (b_clr_busy),
    .clr_done (b_clr_done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain storage, pending flags and a clear-progress counter.
  logic [31:0] m_mem [DEPTH];
  bit          m_pend [DEPTH];
  bit          m_clearing;
  bit          m_done;
  int          m_pos;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        sb;
    logic [4:0]  sa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ep;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = m_mem[a];
    if (!m_clearing && !m_done && wr_en && wr_addr == a) v = merge32(v, wr_data, wr_be);
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) begin
      m_mem[j]  = 32'h0;
      m_pend[j] = 1'b0;
    end
    m_clearing = 1'b0;
    m_done     = 1'b0;
    m_pos      = 0;
  endtask

  task automatic model_step();
    if (m_clearing) begin
      m_mem[m_pos]  = 32'h0;
      m_pend[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == DEPTH) begin
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_mem[wr_addr]  = merge32(m_mem[wr_addr], wr_data, wr_be);
        m_pend[wr_addr] = 1'b0;
      end
      if (sb_set && sb_addr != 5'd0) m_pend[sb_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_pos      = 0;
      end
    end
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm);
    logic [4:0] a;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*AW +: AW];
      chk({nm, "_data"}, 64'(rd_data[i*DW +: DW]), 64'(exp_data(a)));
      chk({nm, "_pend"}, 64'(rd_pend[i]), 64'(m_pend[a]));
    end
    chk({nm, "_busy"}, 64'(clr_busy), 64'(m_clearing));
    chk({nm, "_done"}, 64'(clr_done), 64'(m_done));
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    sb_set    = 1'b0; sb_addr = '0; clr_req = 1'b0; rd_addr = '0;
    b_wr_en   = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
    b_sb_set  = 1'b0; b_sb_addr = '0; b_clr_req = 1'b0; b_rd_addr = '0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
    tbl[2]  = '{1'b1, 5'd5, 32'h11223344, 4'h5, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDE22BE44, 32'hDE22BE44, 2'b00};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDE22BE44, 32'hDE22BE44, 2'b00};
    tbl[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDE22BE44, 2'b00};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDE22BE44, 2'b00};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        2'b00};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h0,        2'b10};
    tbl[8]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 4'hF, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b10};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00};
    tbl[10] = '{1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h12345678, 2'b00};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h12345678, 2'b10};

    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #1;

    // Reset state: every address reads zero with no pending flag.
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk("rst_data0", 64'(rd_data[31:0]), 64'h0);
      chk("rst_data1", 64'(rd_data[63:32]), 64'h0);
      chk("rst_pend", 64'(rd_pend), 64'h0);
    end
    chk("rst_busy", 64'(clr_busy), 64'h0);
    chk("rst_done", 64'(clr_done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: byte enables, r0, bypass, scoreboard races.
    for (int r = 0; r < 12; r++) begin
      wr_en   = tbl[r].we; wr_addr = tbl[r].wa; wr_data = tbl[r].wd; wr_be = tbl[r].be;
      sb_set  = tbl[r].sb; sb_addr = tbl[r].sa;
      rd_addr = {tbl[r].ra1, tbl[r].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", r), 64'(rd_data[31:0]), 64'(tbl[r].e0));
      chk($sformatf("vec%0d_rd1", r), 64'(rd_data[63:32]), 64'(tbl[r].e1));
      chk($sformatf("vec%0d_pend", r), 64'(rd_pend), 64'(tbl[r].ep));
      tick();
    end
    idle_inputs();

    // Randomized traffic against the model, including occasional clears.
    for (int it = 0; it < 400; it++) begin
      wr_en   = 1'($urandom % 2);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      wr_be   = 4'($urandom);
      sb_set  = ($urandom % 4) == 0;
      sb_addr = 5'($urandom);
      clr_req = ($urandom % 100) == 0;
      rd_addr = 10'($urandom);
      #1;
      check_all("rand");
      tick();
    end
    idle_inputs();
    n = 0;
    while ((m_clearing || m_done) && n < 40) begin
      tick();
      n++;
    end

    // Sequenced clear with writes, sets and requests hammered during it.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hC0DE0000 | 32'(a); wr_be = 4'hF;
      tick();
    end
    wr_en = 1'b0; sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    sb_set = 1'b0; clr_req = 1'b1;
    tick();
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
      sb_set = 1'b1; sb_addr = 5'd4; clr_req = 1'b1;
      rd_addr = {5'd31, 5'd3};
      #1;
      check_all("clr");
      tick();
      n++;
    end
    chk("clr_busy_cycles", 64'(n), 64'd32);
    chk("clr_done_pulse", 64'(clr_done), 64'h1);
    check_all("clr_done_state");
    idle_inputs();
    tick();
    chk("clr_done_drop", 64'(clr_done), 64'h0);
    chk("clr_no_restart", 64'(clr_busy), 64'h0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = {5'(a + 16), 5'(a)};
      #1;
      chk("clr_zero_lo", 64'(rd_data[31:0]), 64'h0);
      chk("clr_zero_hi", 64'(rd_data[63:32]), 64'h0);
      chk("clr_pend", 64'(rd_pend), 64'h0);
    end

    // Reset asserted mid-clear at index 10.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55AA55AA; wr_be = 4'hF;
    tick();
    wr_en = 1'b0; sb_set = 1'b1; sb_addr = 5'd25;
    tick();
    sb_set = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rd_addr = {5'd25, 5'd20};
    #1;
    chk("mid_busy", 64'(clr_busy), 64'h1);
    chk("mid_r20", 64'(rd_data[31:0]), 64'h55AA55AA);
    chk("mid_p25", 64'(rd_pend[1]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(clr_busy), 64'h0);
    chk("arst_done", 64'(clr_done), 64'h0);
    chk("arst_r20", 64'(rd_data[31:0]), 64'h0);
    chk("arst_pend", 64'(rd_pend), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      check_all("post_rst");
    end

    // Wide instance: r0 writable, 8-bit byte enables, 16-cycle clear.
    b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h0123456789ABCDEF; b_wr_be = 8'hFF;
    tick();
    b_wr_en = 1'b0;
    #1;
    chk("w_r0_p0", b_rd_data[63:0], 64'h0123456789ABCDEF);
    chk("w_r0_p3", b_rd_data[255:192], 64'h0123456789ABCDEF);
    b_wr_en = 1'b1; b_wr_data = 64'hFFFFFFFFFFFFFFFF; b_wr_be = 8'h0F;
    #1;
    chk("w_bypass", b_rd_data[127:64], 64'h01234567FFFFFFFF);
    tick();
    b_wr_en = 1'b0; b_sb_set = 1'b1; b_sb_addr = 4'd0;
    #1;
    chk("w_be", b_rd_data[255:192], 64'h01234567FFFFFFFF);
    tick();
    b_sb_set = 1'b0;
    #1;
    chk("w_pend_r0", 64'(b_rd_pend), 64'hF);
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    n = 0;
    while (b_clr_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("w_clr_cycles", 64'(n), 64'd16);
    chk("w_clr_done", 64'(b_clr_done), 64'h1);
    tick();
    chk("w_r0_cleared", b_rd_data[63:0], 64'h0);
    chk("w_pend_cleared", 64'(b_rd_pend), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
